envelope_stream_ctrl: RTL and testbench

// - Upstream/downstream host-side controller for the RSA-SM4 envelope top.
// - Opens a session: crypt_pre/den_sel, wait crypt_ready, capture en_cmkey.
// - Packs 32-bit host words into 128-bit SM4 blocks and issues each with in_sync.
// - Collects each out_sync result and unpacks it to a 32-bit output stream. One block in flight.

---
 rtl/envelope_stream_ctrl_if.sv | 11 +
 rtl/envelope_stream_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_envelope_stream_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_stream_ctrl_if.sv
// 32-bit word stream bundle shared by the host input and output sides of
// envelope_stream_ctrl: valid/ready handshake plus data and end-of-message.
interface envelope_stream_ctrl_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/envelope_stream_ctrl.sv
// Host-side session controller for the RSA-SM4 envelope core: 32-bit words in,
// 128-bit blocks to the core, results back out. Optional watchdog: ENV_TIMEOUT_EN.
module envelope_stream_ctrl #(
    parameter logic [31:0] PAD_WORD       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [129:0]           cmkey_in,
    output logic [129:0]           cmkey_out,
    output logic                   busy,
    output logic                   err,
    envelope_stream_ctrl_if.slave  s,
    envelope_stream_ctrl_if.master m,
    output logic                   crypt_pre,
    output logic                   den_sel,
    output logic [129:0]           de_cmkey,
    input  logic [129:0]           en_cmkey,
    input  logic                   crypt_ready,
    output logic [127:0]           core_in,
    output logic                   in_sync,
    input  logic [127:0]           core_out,
    input  logic                   out_sync
);

    typedef enum logic [2:0] {
        IDLE, KEYREQ, KEYWAIT, FILL, ISSUE, WAIT_OUT, DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              den_sel_q, den_sel_d;
    logic [129:0]      de_cmkey_q, de_cmkey_d;
    logic [129:0]      cmkey_q, cmkey_d;
    logic              err_q, err_d;
    logic [1:0]        wc_q, wc_d;
    logic [1:0]        rc_q, rc_d;
    logic [3:0][31:0]  buf_q, buf_d;
    logic [3:0][31:0]  blk_q, blk_d;
    logic [3:0][31:0]  res_q, res_d;
    logic              last_q, last_d;
    logic              tmo_hit;

`ifdef ENV_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Counter restarts on every state change so each wait gets a full window.
    always_comb begin
        tmo_d = 32'd0;
        if (state_d == state_q &&
            (state_q == KEYWAIT || state_q == WAIT_OUT))
            tmo_d = tmo_q + 32'd1;
    end

    assign tmo_hit = (state_q == KEYWAIT || state_q == WAIT_OUT) &&
                     (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= 32'd0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        den_sel_d  = den_sel_q;
        de_cmkey_d = de_cmkey_q;
        cmkey_d    = cmkey_q;
        err_d      = err_q;
        wc_d       = wc_q;
        rc_d       = rc_q;
        buf_d      = buf_q;
        blk_d      = blk_q;
        res_d      = res_q;
        last_d     = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    den_sel_d  = mode;
                    de_cmkey_d = cmkey_in;
                    err_d      = 1'b0;
                    state_d    = KEYREQ;
                end
            end
            KEYREQ: state_d = KEYWAIT;
            KEYWAIT: begin
                if (crypt_ready) begin
                    if (!den_sel_q) cmkey_d = en_cmkey;
                    wc_d    = 2'd0;
                    state_d = FILL;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (s.valid) begin
                    // Slot 0 sits in the top word; a short block pads the tail.
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == wc_q)
                            buf_d[3-i] = s.data;
                        else if (2'(i) > wc_q && s.last)
                            buf_d[3-i] = PAD_WORD;
                    end
                    wc_d = wc_q + 2'd1;
                    if (wc_q == 2'd3 || s.last) begin
                        blk_d   = buf_d;
                        last_d  = s.last;
                        wc_d    = 2'd0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (out_sync) begin
                    res_d   = core_out;
                    rc_d    = 2'd0;
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    wc_d    = 2'd0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (m.ready) begin
                    rc_d = rc_q + 2'd1;
                    if (rc_q == 2'd3)
                        state_d = last_q ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            den_sel_q  <= 1'b0;
            de_cmkey_q <= '0;
            cmkey_q    <= '0;
            err_q      <= 1'b0;
            wc_q       <= 2'd0;
            rc_q       <= 2'd0;
            buf_q      <= '0;
            blk_q      <= '0;
            res_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            den_sel_q  <= den_sel_d;
            de_cmkey_q <= de_cmkey_d;
            cmkey_q    <= cmkey_d;
            err_q      <= err_d;
            wc_q       <= wc_d;
            rc_q       <= rc_d;
            buf_q      <= buf_d;
            blk_q      <= blk_d;
            res_q      <= res_d;
            last_q     <= last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign cmkey_out = cmkey_q;
    assign den_sel   = den_sel_q;
    assign de_cmkey  = de_cmkey_q;
    assign core_in   = blk_q;
    assign crypt_pre = (state_q == KEYREQ) && !rst;
    assign in_sync   = (state_q == ISSUE) && !rst;
    assign s.ready   = (state_q == FILL);
    assign m.valid   = (state_q == DRAIN);
    assign m.data    = res_q[2'd3 - rc_q];
    assign m.last    = (state_q == DRAIN) && (rc_q == 2'd3) && last_q;

endmodule

// File: tb/tb_envelope_stream_ctrl.sv
// Randomised scoreboard bench for envelope_stream_ctrl with a behavioural
// core model (key ready after 20 cycles, result after 10, XOR cipher).
module tb_envelope_stream_ctrl;

    localparam logic [31:0]  MASK   = 32'hA5A5A5A5;
    localparam logic [129:0] EN_KEY = 130'h1_2345;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [129:0] cmkey_in, cmkey_out, de_cmkey, en_cmkey;
    logic         busy, err, crypt_pre, den_sel, crypt_ready;
    logic         in_sync, out_sync;
    logic [127:0] core_in, core_out;

    envelope_stream_ctrl_if s_bus();
    envelope_stream_ctrl_if m_bus();

    envelope_stream_ctrl #(
        .PAD_WORD       (32'h0000_0000),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .cmkey_in    (cmkey_in),
        .cmkey_out   (cmkey_out),
        .busy        (busy),
        .err         (err),
        .s           (s_bus),
        .m           (m_bus),
        .crypt_pre   (crypt_pre),
        .den_sel     (den_sel),
        .de_cmkey    (de_cmkey),
        .en_cmkey    (en_cmkey),
        .crypt_ready (crypt_ready),
        .core_in     (core_in),
        .in_sync     (in_sync),
        .core_out    (core_out),
        .out_sync    (out_sync)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [32:0]  exp_q[$];
    logic [127:0] blk_q[$];
    logic [31:0]  msg[$];
    logic [129:0] exp_key = '0;
    int           pre_cnt = 0;
    int           sync_cnt = 0;
    bit           exp_den = 1'b0;
    bit           chk_den = 1'b0;
    bit           no_out = 1'b0;
    bit           inj_req = 1'b0;
    int           mr_mode = 0;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        total++;
        $display("FAIL %s: got event-missing expected event", name);
    endtask

    // Core model: reacts to strobes seen mid-cycle, drives on the falling edge.
    initial begin
        int           kc;
        int           oc;
        logic [127:0] cap;
        kc = -1;
        oc = -1;
        cap = '0;
        crypt_ready = 1'b0;
        out_sync = 1'b0;
        core_out = '0;
        en_cmkey = EN_KEY;
        forever begin
            @(negedge clk);
            crypt_ready = 1'b0;
            out_sync = 1'b0;
            if (rst) begin
                kc = -1;
                oc = -1;
            end else begin
                if (kc == 0) crypt_ready = 1'b1;
                if (kc >= 0) kc--;
                if (oc == 0) begin
                    out_sync = 1'b1;
                    core_out = cap ^ {4{MASK}};
                end
                if (oc >= 0) oc--;
                if (crypt_pre) kc = 19;
                if (in_sync && !no_out) begin
                    oc = 9;
                    cap = core_in;
                end
                if (inj_req) begin
                    out_sync = 1'b1;
                    core_out = {4{32'hDEADBEEF}};
                end
            end
        end
    end

    // Downstream ready: always on, or a repeating 1-0-0-1 pattern.
    initial begin
        int ph;
        ph = 0;
        m_bus.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mr_mode == 0) begin
                m_bus.ready = 1'b1;
            end else begin
                m_bus.ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    // Monitor: compares every presented output word and every issued block.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (crypt_pre) pre_cnt++;
                if (in_sync) begin
                    sync_cnt++;
                    if (blk_q.size() == 0) note_fail("unexpected_in_sync");
                    else check("core_in", core_in, blk_q.pop_front());
                end
                if (m_bus.valid) begin
                    if (exp_q.size() == 0) begin
                        note_fail("unexpected_m_valid");
                    end else begin
                        check("m_word", {m_bus.last, m_bus.data}, exp_q[0]);
                        if (m_bus.ready) void'(exp_q.pop_front());
                    end
                end
                if (chk_den && busy) check("den_sel_held", den_sel, exp_den);
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input bit lst,
                             input bit gaps);
        int g;
        int t;
        g = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        s_bus.valid = 1'b1;
        s_bus.data = d;
        s_bus.last = lst;
        t = 0;
        @(negedge clk);
        while (!s_bus.ready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 3000) note_fail("s_handshake_timeout");
        @(posedge clk);
        #1;
        s_bus.valid = 1'b0;
        s_bus.last = 1'b0;
    endtask

    task automatic pulse_start(input bit md, input logic [129:0] key);
        mode = md;
        cmkey_in = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~md;
        cmkey_in = ~key;
    endtask

    task automatic wait_in_sync();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_sync && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) note_fail("in_sync_timeout");
    endtask

    task automatic session(input bit md, input logic [129:0] key,
                           input bit gaps, input bit poke);
        int n;
        int nblk;
        int t;
        logic [127:0] b128;
        logic [31:0]  v;
        n = msg.size();
        nblk = (n + 3) / 4;
        for (int b = 0; b < nblk; b++) begin
            b128 = '0;
            for (int k = 0; k < 4; k++) begin
                v = (4 * b + k < n) ? msg[4*b+k] : 32'h0;
                b128[127-32*k -: 32] = v;
                exp_q.push_back({(b == nblk - 1 && k == 3), v ^ MASK});
            end
            blk_q.push_back(b128);
        end
        pre_cnt = 0;
        sync_cnt = 0;
        exp_den = md;
        pulse_start(md, key);
        chk_den = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_word(msg[i], (i == n - 1), gaps);
            if (poke && i == 0) begin
                start = 1'b1;
                inj_req = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                inj_req = 1'b0;
            end
        end
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) note_fail("session_timeout");
        chk_den = 1'b0;
        exp_q.delete();
        blk_q.delete();
        if (!md) exp_key = EN_KEY;
        check("crypt_pre_count", pre_cnt, 1);
        check("in_sync_count", sync_cnt, nblk);
        check("cmkey_out", cmkey_out, exp_key);
        check("de_cmkey", de_cmkey, key);
        check("den_sel_after", den_sel, md);
        check("err_clear", err, 1'b0);
    endtask

    task automatic load_count(input int n, input logic [31:0] base,
                              input logic [31:0] step);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(base + step * i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_crypt_pre"}, crypt_pre, 1'b0);
        check({tag, "_in_sync"}, in_sync, 1'b0);
        check({tag, "_s_ready"}, s_bus.ready, 1'b0);
        check({tag, "_m_valid"}, m_bus.valid, 1'b0);
        check({tag, "_m_data"}, m_bus.data, 32'h0);
        check({tag, "_m_last"}, m_bus.last, 1'b0);
        check({tag, "_core_in"}, core_in, 128'h0);
        check({tag, "_cmkey_out"}, cmkey_out, 130'h0);
        check({tag, "_den_sel"}, den_sel, 1'b0);
        check({tag, "_de_cmkey"}, de_cmkey, 130'h0);
    endtask

    initial begin
        logic [129:0] kd;
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        cmkey_in = '0;
        s_bus.valid = 1'b0;
        s_bus.data = '0;
        s_bus.last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        kd = {2'b10, 64'hCAFE_F00D_0123_4567, 64'h89AB_CDEF_1357_9BDF};

        load_count(8, 32'h0, 32'h1);
        session(1'b0, 130'h0, 1'b0, 1'b0);

        load_count(5, 32'h1111_1111, 32'h1111_1111);
        session(1'b1, kd, 1'b0, 1'b0);

        mr_mode = 1;
        load_count(8, 32'h0, 32'h1);
        session(1'b0, 130'h5, 1'b1, 1'b0);
        mr_mode = 0;

        load_count(8, 32'h0, 32'h1);
        session(1'b0, 130'h7, 1'b0, 1'b1);

        pulse_start(1'b0, 130'h9);
        blk_q.push_back({32'hA, 32'hB, 32'hC, 32'hD});
        send_word(32'hA, 1'b0, 1'b0);
        send_word(32'hB, 1'b0, 1'b0);
        send_word(32'hC, 1'b0, 1'b0);
        send_word(32'hD, 1'b0, 1'b0);
        wait_in_sync();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_key = '0;
        blk_q.delete();
        check_all_zero("midrst");
        load_count(6, 32'h100, 32'h3);
        session(1'b0, 130'h11, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  md;
            n = int'($urandom_range(1, 13));
            md = 1'($urandom_range(0, 1));
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back($urandom());
            mr_mode = int'($urandom_range(0, 1));
            session(md, {2'($urandom()), 64'($urandom()), 64'($urandom())},
                    1'b1, (n > 1) && ($urandom_range(0, 1) == 1));
        end
        mr_mode = 0;

`ifdef ENV_TIMEOUT_EN
        no_out = 1'b1;
        pulse_start(1'b0, 130'h21);
        blk_q.push_back({32'h1, 32'h2, 32'h3, 32'h4});
        send_word(32'h1, 1'b0, 1'b0);
        send_word(32'h2, 1'b0, 1'b0);
        send_word(32'h3, 1'b0, 1'b0);
        send_word(32'h4, 1'b0, 1'b0);
        wait_in_sync();
        @(posedge clk);
        repeat (63) @(posedge clk);
        #1;
        check("tmo_busy_before", busy, 1'b1);
        check("tmo_err_before", err, 1'b0);
        @(posedge clk);
        #1;
        check("tmo_busy_after", busy, 1'b0);
        check("tmo_err_after", err, 1'b1);
        no_out = 1'b0;
        blk_q.delete();
        load_count(3, 32'h77, 32'h1);
        session(1'b0, 130'h22, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
